bcl_block_serial_subtractor: RTL and testbench

- Multi-cycle block carry look-ahead subtractor: computes D = X - Y one BLOCK-bit block per cycle, LSB block first.
- Uses X + ~Y + 1 with per-block generate/propagate look-ahead; borrow = NOT carry-out.
- Inverse companion of the team's combinational block carry look-ahead adders; used where area beats latency (checkers, accumulator datapaths).
- Valid/ready on both input and output.

---
 rtl/bcl_block_serial_subtractor_pkg.sv | 23 ++
 rtl/bcl_block_serial_subtractor_if.sv | 28 ++
 rtl/bcl_block_serial_subtractor_block_unit.sv | 51 +++++
 rtl/bcl_block_serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_bcl_block_serial_subtractor.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/bcl_block_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the block-serial CLA subtractor.
package bcls_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } bcls_state_e;

    localparam int BCLS_WIDTH = 8;
    localparam int BCLS_BLOCK = 4;

    function automatic int bcls_nblk(input int w, input int b);
        return w / b;
    endfunction

    function automatic int bcls_blk_w(input int w, input int b);
        int n;
        n = w / b;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcl_block_serial_subtractor_if.sv
// Operand/result valid-ready bundle for the block-serial subtractor.
interface bcls_if
    import bcls_pkg::*;
#(
    parameter int WIDTH = BCLS_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             borrow;
    logic             ovf;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, d, borrow, ovf
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, d, borrow, ovf
    );

endinterface

// File: rtl/bcl_block_serial_subtractor_block_unit.sv
// One BLOCK-bit look-ahead adder slice with group generate/propagate.
module bcls_block_unit #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             go_o,
    output logic             po_o
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Each internal carry is the flattened sum-of-products, not a ripple.
    always_comb begin
        logic acc;
        logic pp;
        c = '0;
        for (int i = 0; i < BLOCK; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i] = acc | (pp & cin_i);
        end
    end

    always_comb begin
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        for (int j = BLOCK - 1; j >= 0; j--) begin
            acc = acc | (pp & g[j]);
            pp  = pp & p[j];
        end
        go_o = acc;
    end

    assign po_o  = &p;
    assign sum_o = p ^ c;

endmodule

// File: rtl/bcl_block_serial_subtractor.sv
// Block-serial CLA subtractor: D = X + ~Y + 1, one block per cycle.
// Define BCLS_SIGNED_OVF_EN to register a signed-overflow flag.
module bcl_block_serial_subtractor
    import bcls_pkg::*;
#(
    parameter int WIDTH = BCLS_WIDTH,
    parameter int BLOCK = BCLS_BLOCK
) (
    input logic   clk,
    input logic   rst_n,
    bcls_if.slave io
);

    localparam int NBLK = bcls_nblk(WIDTH, BLOCK);
    localparam int BW   = bcls_blk_w(WIDTH, BLOCK);
    localparam logic [BW-1:0] LAST = BW'(NBLK - 1);

    bcls_state_e      state_q, state_d;
    logic [BW-1:0]    blk_q, blk_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] xa_q, xa_d;
    logic [WIDTH-1:0] yb_q, yb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;

    logic [BLOCK-1:0] a_sl;
    logic [BLOCK-1:0] b_sl;
    logic [BLOCK-1:0] sum;
    logic             go;
    logic             po;
    logic             cout;
    logic             last;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NBLK; i++) begin
            if (blk_q == BW'(i)) begin
                a_sl = xa_q[i*BLOCK +: BLOCK];
                b_sl = yb_q[i*BLOCK +: BLOCK];
            end
        end
    end

    bcls_block_unit #(
        .BLOCK (BLOCK)
    ) u_blk (
        .a_i   (a_sl),
        .b_i   (b_sl),
        .cin_i (carry_q),
        .sum_o (sum),
        .go_o  (go),
        .po_o  (po)
    );

    assign cout = go | (po & carry_q);
    assign last = (blk_q == LAST);

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        carry_d  = carry_q;
        xa_d     = xa_q;
        yb_d     = yb_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        unique case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    xa_d    = io.x;
                    yb_d    = ~io.y;
                    carry_d = 1'b1;
                    blk_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NBLK; i++) begin
                    if (blk_q == BW'(i)) begin
                        d_d[i*BLOCK +: BLOCK] = sum;
                    end
                end
                carry_d = cout;
                blk_d   = blk_q + BW'(1);
                if (last) begin
                    borrow_d = ~cout;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            carry_q  <= 1'b1;
            xa_q     <= '0;
            yb_q     <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            carry_q  <= carry_d;
            xa_q     <= xa_d;
            yb_q     <= yb_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef BCLS_SIGNED_OVF_EN
    logic ovf_q, ovf_d;

    // yb_q holds ~y, so equal stored MSBs mean x and y signs differ.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_RUN && last) begin
            ovf_d = (xa_q[WIDTH-1] == yb_q[WIDTH-1]) &&
                    (sum[BLOCK-1] != xa_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign io.ovf = ovf_q;
`else
    assign io.ovf = 1'b0;
`endif

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = (state_q == S_DONE);
    assign io.d         = d_q;
    assign io.borrow    = borrow_q;

endmodule

// File: tb/tb_bcl_block_serial_subtractor.sv
// Scoreboard bench for bcl_block_serial_subtractor (8-bit, 4-bit blocks).
module tb_bcl_block_serial_subtractor;
    import bcls_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    bit   rand_rdy = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;

    bcls_if #(.WIDTH(W)) io ();

    bcl_block_serial_subtractor #(
        .WIDTH (W),
        .BLOCK (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d = x - y;
        e.b = (x < y);
`ifdef BCLS_SIGNED_OVF_EN
        e.o = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%h required=none", io.d);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result_d", 32'(io.d), 32'(e.d));
                check("result_borrow", 32'(io.borrow), 32'(e.b));
                check("result_ovf", 32'(io.ovf), 32'(e.o));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            io.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!io.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) check("send_timeout", 32'(io.in_ready), 32'd1);
        io.in_valid = 1'b1;
        io.x = x;
        io.y = y;
        if (push) q.push_back(model(x, y));
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.x = W'($urandom);
        io.y = W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        io.in_valid = 1'b0;
        io.x = '0;
        io.y = '0;
        io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(io.in_ready), 32'd1);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_d", 32'(io.d), 32'd0);
        check("rst_borrow", 32'(io.borrow), 32'd0);
        check("rst_ovf", 32'(io.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        io.out_ready = 1'b1;
        send(8'h35, 8'h12, 1'b1);
        @(negedge clk);
        check("lat_c0_valid", 32'(io.out_valid), 32'd0);
        check("busy_in_ready", 32'(io.in_ready), 32'd0);
        @(negedge clk);
        check("lat_c1_valid", 32'(io.out_valid), 32'd0);
        @(negedge clk);
        check("lat_c2_valid", 32'(io.out_valid), 32'd1);

        send(8'h00, 8'h01, 1'b1);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'h80, 8'h01, 1'b1);
        drain();

        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        send(8'hA0, 8'h0F, 1'b1);
        @(posedge clk);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(io.out_valid), 32'd1);
            check("bp_d", 32'(io.d), 32'h91);
            check("bp_in_ready", 32'(io.in_ready), 32'd0);
            if (i == 1) begin
                io.in_valid = 1'b1;
                io.x = 8'h11;
                io.y = 8'h00;
            end
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hs_in_ready", 32'(io.in_ready), 32'd1);
        check("post_hs_valid", 32'(io.out_valid), 32'd0);
        drain();

        send(8'h50, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(io.out_valid), 32'd0);
        check("abort_d", 32'(io.d), 32'd0);
        check("abort_in_ready", 32'(io.in_ready), 32'd1);
        check("abort_borrow", 32'(io.borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h05, 8'h07, 1'b1);
        drain();

        rand_rdy = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            send(W'($urandom), W'($urandom), 1'b1);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        io.out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
